// File: rtl/alsu_ctrl_pkg.sv
// Shared types, opcode constants and flag positions for the ALSU request
// arbiter/controller, plus the command legality check.
package alsu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] a;
        logic [2:0] b;
        logic [6:0] flags;
    } alsu_cmd_t;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    localparam int FLAG_CIN       = 6;
    localparam int FLAG_RED_A     = 5;
    localparam int FLAG_RED_B     = 4;
    localparam int FLAG_BYPASS_A  = 3;
    localparam int FLAG_BYPASS_B  = 2;
    localparam int FLAG_DIRECTION = 1;
    localparam int FLAG_SERIAL_IN = 0;

    // Reduction modes only make sense for the bitwise AND/OR opcodes.
    function automatic logic cmd_illegal(input alsu_cmd_t cmd);
        logic red_s;
        red_s = cmd.flags[FLAG_RED_A] | cmd.flags[FLAG_RED_B];
        return (cmd.opcode == 3'd6) || (cmd.opcode == 3'd7) ||
               (red_s && (cmd.opcode != OP_AND) && (cmd.opcode != OP_OR));
    endfunction

endpackage

// File: rtl/alsu_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins;
// the pointer moves only when the caller signals a completed transfer.
module alsu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;

    // Grant selection from current requests and last-granted pointer.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

    // Last-granted pointer; reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end else begin
            last_q <= last_q;
        end
    end

endmodule

// File: rtl/alsu_arb_ctrl.sv
// Arbitrates two requesters onto a single ALSU, waits LATENCY cycles for the
// result and returns it over a valid/ready response channel.
module alsu_arb_ctrl
    import alsu_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY        = 2,
    parameter              INPUT_PRIORITY = "A"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_opcode,
    input  logic [2:0]  req0_a,
    input  logic [2:0]  req0_b,
    input  logic [6:0]  req0_flags,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_opcode,
    input  logic [2:0]  req1_a,
    input  logic [2:0]  req1_b,
    input  logic [6:0]  req1_flags,
    output logic [2:0]  alsu_opcode,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic [6:0]  alsu_flags,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic        rsp_leds
);

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_e     state_q;
    logic [3:0] wait_cnt_q;
    alsu_cmd_t  alsu_q;
    logic [1:0] valid_s;
    logic [1:0] grant_s;
    logic       xfer_s;
    alsu_cmd_t  req_cmd_s;

    alsu_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid_s),
        .advance (xfer_s),
        .grant   (grant_s)
    );

    // Requests are only visible to the arbiter while idle; ready is forced low in reset.
    always_comb begin
        valid_s    = (state_q == IDLE) ? {req1_valid, req0_valid} : 2'b00;
        req0_ready = grant_s[0] & rst_n;
        req1_ready = grant_s[1] & rst_n;
        xfer_s     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
        if (grant_s[1]) begin
            req_cmd_s = {req1_opcode, req1_a, req1_b, req1_flags};
        end else begin
            req_cmd_s = {req0_opcode, req0_a, req0_b, req0_flags};
        end
    end

    assign alsu_opcode = alsu_q.opcode;
    assign alsu_a      = alsu_q.a;
    assign alsu_b      = alsu_q.b;
    assign alsu_flags  = alsu_q.flags;

    // Control FSM with registered ALSU pins and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            alsu_q     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 6'd0;
            rsp_err    <= 1'b0;
            rsp_leds   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_s) begin
                        rsp_id <= grant_s[1];
                        if (cmd_illegal(req_cmd_s)) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 6'd0;
                            rsp_leds  <= 1'b0;
                            state_q   <= RESP;
                        end else begin
                            // Pins load here so they are live for the whole ISSUE cycle.
                            alsu_q  <= req_cmd_s;
                            rsp_err <= 1'b0;
                            state_q <= ISSUE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= 4'd0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_q == LAST_CNT) begin
                        wait_cnt_q <= 4'd0;
                        rsp_data   <= alsu_out;
                        rsp_leds   <= |alsu_leds;
                        rsp_valid  <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_arb_ctrl.sv
// Directed bench for alsu_arb_ctrl; a small behavioural ALSU answers on the
// alsu_* pins so response data can be checked against hand-computed values.
module tb_alsu_arb_ctrl;

    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_opcode, req0_a, req0_b, req1_opcode, req1_a, req1_b;
    logic [6:0]  req0_flags, req1_flags;
    logic [2:0]  alsu_opcode, alsu_a, alsu_b;
    logic [6:0]  alsu_flags;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, rsp_leds;
    logic [5:0]  rsp_data;
    logic signed [5:0] sa, sb;
    int n_checks, n_fail;

    alsu_arb_ctrl #(.LATENCY(2), .INPUT_PRIORITY("A")) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_flags(req0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_flags(req1_flags),
        .alsu_opcode(alsu_opcode), .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_flags(alsu_flags),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_leds(rsp_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALSU: combinational from the held pins.
    always_comb begin
        sa = {{3{alsu_a[2]}}, alsu_a};
        sb = {{3{alsu_b[2]}}, alsu_b};
        case (alsu_opcode)
            3'd0: alsu_out = alsu_flags[5] ? {5'd0, &alsu_a} : (alsu_flags[4] ? {5'd0, &alsu_b} : {3'd0, alsu_a & alsu_b});
            3'd1: alsu_out = alsu_flags[5] ? {5'd0, |alsu_a} : (alsu_flags[4] ? {5'd0, |alsu_b} : {3'd0, alsu_a | alsu_b});
            3'd2: alsu_out = sa + sb + {5'd0, alsu_flags[6]};
            3'd3: alsu_out = sa * sb;
            default: alsu_out = 6'd0;
        endcase
    end

    task automatic drive_req(input int n, input logic v, input logic [2:0] op, input logic [2:0] a,
                             input logic [2:0] b, input logic [6:0] fl);
        if (n == 0) begin
            req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_flags = fl;
        end else begin
            req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_flags = fl;
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle after the transfer.
    task automatic issue_req(input int n, input logic [2:0] op, input logic [2:0] a,
                             input logic [2:0] b, input logic [6:0] fl, output bit granted);
        int k;
        drive_req(n, 1'b1, op, a, b, fl);
        #1;
        k = 0;
        granted = 1'b0;
        while (k < 20 && !granted) begin
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) granted = 1'b1;
            else begin @(posedge clk); #1; k++; end
        end
        if (granted) begin @(posedge clk); #1; end
        drive_req(n, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
    endtask

    // Cycle index (1 = cycle after transfer) at which rsp_valid is first seen.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic accept_rsp;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_req(0, 1'b1, 3'd2, 3'd1, 3'd1, 7'd0);
        drive_req(1, 1'b1, 3'd2, 3'd1, 3'd1, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
        n_checks++; if (rsp_data !== 6'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_leds !== 1'b0) begin n_fail++; $display("FAIL reset_payload: got data=%0h id=%0h err=%0h leds=%0h expected all 0", rsp_data, rsp_id, rsp_err, rsp_leds); end
        n_checks++; if ({alsu_opcode, alsu_a, alsu_b, alsu_flags} !== 16'd0) begin n_fail++; $display("FAIL reset_alsu_pins: got %0h expected 0", {alsu_opcode, alsu_a, alsu_b, alsu_flags}); end
        n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %0b expected 00", {req1_ready, req0_ready}); end
        drive_req(0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int k, cyc;
        logic exp_id;
        rsp_ready = 1'b1;
        alsu_leds = 16'h8000;
        drive_req(0, 1'b1, 3'd3, 3'd2, 3'd3, 7'd0);
        drive_req(1, 1'b1, 3'd3, 3'd2, 3'd3, 7'd0);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            k = 0;
            while (k < 20 && !(req0_ready | req1_ready)) begin @(posedge clk); #1; k++; end
            n_checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_grant%0d: got %0b expected %0b", i, {req1_ready, req0_ready}, (exp_id ? 2'b10 : 2'b01)); end
            @(posedge clk); #1;
            wait_rsp(cyc);
            n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d expected 4", i, cyc); end
            n_checks++; if (rsp_data !== 6'd6 || rsp_id !== exp_id || rsp_err !== 1'b0 || rsp_leds !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp%0d: got data=%0d id=%0h err=%0h leds=%0h expected data=6 id=%0h err=0 leds=1", i, rsp_data, rsp_id, rsp_err, rsp_leds, exp_id); end
            @(posedge clk); #1;
        end
        drive_req(0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        rsp_ready = 1'b0;
        alsu_leds = 16'h0000;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_add;
        bit g;
        int cyc;
        issue_req(0, 3'd2, 3'd1, 3'd2, 7'b1000000, g);
        n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL add_grant: got %0h expected 1", g); end
        n_checks++; if ({alsu_opcode, alsu_a, alsu_b, alsu_flags} !== {3'd2, 3'd1, 3'd2, 7'b1000000}) begin n_fail++; $display("FAIL add_pins: got %0h expected %0h", {alsu_opcode, alsu_a, alsu_b, alsu_flags}, {3'd2, 3'd1, 3'd2, 7'b1000000}); end
        wait_rsp(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL add_latency: got %0d expected 4", cyc); end
        n_checks++; if (rsp_data !== 6'd4 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_leds !== 1'b0) begin n_fail++; $display("FAIL add_rsp: got data=%0d id=%0h err=%0h leds=%0h expected data=4 id=0 err=0 leds=0", rsp_data, rsp_id, rsp_err, rsp_leds); end
        accept_rsp();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp_drop: got %0h expected 0", rsp_valid); end
    endtask

    task automatic test_illegal_opcode;
        bit g;
        int cyc;
        issue_req(1, 3'd6, 3'd1, 3'd1, 7'd0, g);
        n_checks++; if (g !== 1'b1) begin n_fail++; $display("FAIL ill_grant: got %0h expected 1", g); end
        wait_rsp(cyc);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL ill_latency: got %0d expected 1", cyc); end
        n_checks++; if (rsp_err !== 1'b1 || rsp_data !== 6'd0 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL ill_rsp: got err=%0h data=%0d id=%0h expected err=1 data=0 id=1", rsp_err, rsp_data, rsp_id); end
        n_checks++; if ({alsu_opcode, alsu_a, alsu_b, alsu_flags} !== {3'd2, 3'd1, 3'd2, 7'b1000000}) begin n_fail++; $display("FAIL ill_pins_held: got %0h expected %0h", {alsu_opcode, alsu_a, alsu_b, alsu_flags}, {3'd2, 3'd1, 3'd2, 7'b1000000}); end
        accept_rsp();
    endtask

    task automatic test_red_op;
        bit g;
        int cyc;
        issue_req(0, 3'd2, 3'd3, 3'd3, 7'b0100000, g);
        wait_rsp(cyc);
        n_checks++; if (cyc !== 1 || rsp_err !== 1'b1 || rsp_data !== 6'd0) begin n_fail++; $display("FAIL red_illegal: got cyc=%0d err=%0h data=%0d expected cyc=1 err=1 data=0", cyc, rsp_err, rsp_data); end
        accept_rsp();
        issue_req(0, 3'd0, 3'd7, 3'd0, 7'b0100000, g);
        wait_rsp(cyc);
        n_checks++; if (cyc !== 4 || rsp_err !== 1'b0 || rsp_data !== 6'd1) begin n_fail++; $display("FAIL red_and: got cyc=%0d err=%0h data=%0d expected cyc=4 err=0 data=1", cyc, rsp_err, rsp_data); end
        accept_rsp();
    endtask

    task automatic test_rsp_stall;
        bit g;
        int cyc;
        issue_req(0, 3'd2, 3'd3, 3'd7, 7'd0, g);
        wait_rsp(cyc);
        drive_req(0, 1'b1, 3'd2, 3'd1, 3'd1, 7'd0);
        drive_req(1, 1'b1, 3'd2, 3'd1, 3'd1, 7'd0);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 6'd2 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL stall_rsp%0d: got v=%0h data=%0d id=%0h err=%0h expected v=1 data=2 id=0 err=0", i, rsp_valid, rsp_data, rsp_id, rsp_err); end
            n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_ready%0d: got %0b expected 00", i, {req1_ready, req0_ready}); end
            @(posedge clk); #1;
        end
        drive_req(0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        accept_rsp();
    endtask

    task automatic test_reset_mid_wait;
        bit g;
        int cyc, seen;
        issue_req(1, 3'd3, 3'd2, 3'd3, 7'd0, g);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_req(0, 1'b1, 3'd2, 3'd1, 3'd1, 7'd0);
        drive_req(1, 1'b1, 3'd2, 3'd1, 3'd1, 7'd0);
        #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_err, rsp_leds} !== 10'd0) begin n_fail++; $display("FAIL midrst_rsp: got %0h expected 0", {rsp_valid, rsp_id, rsp_data, rsp_err, rsp_leds}); end
        n_checks++; if ({alsu_opcode, alsu_a, alsu_b, alsu_flags} !== 16'd0) begin n_fail++; $display("FAIL midrst_pins: got %0h expected 0", {alsu_opcode, alsu_a, alsu_b, alsu_flags}); end
        n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL midrst_ready: got %0b expected 00", {req1_ready, req0_ready}); end
        drive_req(0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d response cycles expected 0", seen); end
        drive_req(0, 1'b1, 3'd2, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b1, 3'd2, 3'd0, 3'd0, 7'd0);
        #1;
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL midrst_tie: got %0b expected 01", {req1_ready, req0_ready}); end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        wait_rsp(cyc);
        n_checks++; if (cyc !== 4 || rsp_id !== 1'b0 || rsp_data !== 6'd0) begin n_fail++; $display("FAIL midrst_after: got cyc=%0d id=%0h data=%0d expected cyc=4 id=0 data=0", cyc, rsp_id, rsp_data); end
        accept_rsp();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rsp_ready = 1'b0;
        alsu_leds = 16'h0000;
        drive_req(0, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        drive_req(1, 1'b0, 3'd0, 3'd0, 3'd0, 7'd0);
        test_reset();
        test_back_to_back();
        test_basic_add();
        test_illegal_opcode();
        test_red_op();
        test_rsp_stall();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alsu_arb_ctrl.md
ALSU_ARB_CTRL -- requirements
Module: alsu_arb_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from ISSUE to a valid ALSU result.
REQ-002 SHALL have parameter INPUT_PRIORITY, default "A", carried for protocol checks only; it has no effect on arbitration.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports reqN_valid (input, 1 bit) and reqN_ready (output, 1 bit) for N=0,1, a valid/ready request handshake.
REQ-006 SHALL have reqN_opcode (input, 3 bits), reqN_a (input, 3 bits) and reqN_b (input, 3 bits) for N=0,1, the operation and signed operands.
REQ-007 SHALL have reqN_flags, input, 7 bits, for N=0,1: {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in}.
REQ-008 SHALL have ALSU drive outputs alsu_opcode (3 bits), alsu_a (3 bits), alsu_b (3 bits) and alsu_flags (7 bits), with the same bit order as reqN_flags.
REQ-009 SHALL have ALSU result inputs alsu_out (6 bits) and alsu_leds (16 bits).
REQ-010 SHALL have response handshake ports rsp_valid (output, 1 bit) and rsp_ready (input, 1 bit).
REQ-011 SHALL have response payload outputs rsp_id (1 bit, granted requester), rsp_data (6 bits), rsp_err (1 bit, rejected command) and rsp_leds (1 bit, alsu_leds nonzero at capture).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-013 SHALL, in IDLE with any reqN_valid, grant by round-robin; if both are valid, the requester not granted last wins.
REQ-014 SHALL assert reqN_ready combinationally, in IDLE only, for the granted requester only; the transfer is valid&ready.
REQ-015 SHALL, on transfer, latch the command and rsp_id and go to ISSUE if the command is legal, else go directly to RESP with rsp_err=1 and rsp_data=0.
REQ-016 SHALL treat a command as illegal if opcode is 6 or 7, or if (red_op_A|red_op_B) is set with opcode not equal to 0 or 1.
REQ-017 SHALL, in ISSUE (one cycle), drive the latched command onto the alsu_* pins, then go to WAIT.
REQ-018 SHALL keep the alsu_* pins holding the last issued command until the next ISSUE, including in IDLE and RESP.
REQ-019 SHALL, in WAIT, count LATENCY cycles with a counter wide enough for LATENCY at most 15.
REQ-020 SHALL, on the final WAIT cycle, capture alsu_out into rsp_data and (alsu_leds!=0) into rsp_leds, then go to RESP.
REQ-021 SHALL, in RESP, hold rsp_valid=1 with a stable payload until rsp_ready=1; on rsp_valid&rsp_ready, go to IDLE.
REQ-022 SHALL accept no new request before that return to IDLE, so at most one command is outstanding.
REQ-023 SHALL update the last-granted pointer only on a transfer.
REQ-024 SHALL ignore requests that drop valid before being granted.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-WAIT or mid-RESP, immediately set state=IDLE.
REQ-026 SHALL, on rst_n low, set rsp_valid, rsp_id, rsp_data, rsp_err and rsp_leds to 0.
REQ-027 SHALL, on rst_n low, set the alsu_* pins and both reqN_ready to 0.
REQ-028 SHALL, on rst_n low, set the WAIT counter to 0 and the last-granted pointer to 1, so requester 0 wins the first tie.
REQ-029 SHALL discard an in-flight command on reset and emit no response for it.

Structure
REQ-030 SHALL place the state enum, a cmd struct (opcode, a, b, flags), opcode constants (AND=0, OR=1, ADD=2, MUL=3, SHIFT=4, ROTATE=5) and flag bit indices in package alsu_ctrl_pkg.
REQ-031 SHALL implement the 2-way round-robin grant in sub-module alsu_rr_arb (inputs valid[1:0] and advance; output grant one-hot).

Verification
REQ-032 SHALL test: req0 opcode 2, a=1, b=2, cin=1 -> alsu pins driven 1 cycle after transfer; rsp_valid 1+LATENCY+1 cycles after transfer; rsp_data=4, rsp_id=0, rsp_err=0.
REQ-033 SHALL test: both requesters valid continuously, opcode 3, a=2, b=3 -> grants alternate 0,1,0,1 and each rsp_data=6.
REQ-034 SHALL test: req1 opcode 6 -> no ISSUE cycle; rsp_valid the cycle after transfer with rsp_err=1, rsp_data=0, alsu pins unchanged.
REQ-035 SHALL test: req0 opcode 2 with red_op_A=1 -> rsp_err=1; a following legal opcode 0 with red_op_A=1, a=7 -> rsp_data=1.
REQ-036 SHALL test: rsp_ready held low 5 cycles -> rsp_valid and payload stable for all 5 cycles and both reqN_ready stay 0.
REQ-037 SHALL test: rst_n pulsed low mid-WAIT -> all outputs 0 the same cycle, no response, and the next tie is granted to req0.
